// File: rtl/spi_flash_arbiter_if.sv
// Purpose: bundles the request/grant handshake, both requesters' SPI drive and the flash pins.
// Latency: none (wiring only).
// Backpressure: n/a; slave = arbiter side, master = requester/board side.
// Signals: req/gnt handshake, m0_*/m1_* requester drive, spi_* flash pins, busy.
interface spi_flash_arbiter_if;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       m0_cs;
  logic       m0_sck;
  logic       m0_mosi;
  logic       m1_cs;
  logic       m1_sck;
  logic       m1_mosi;
  logic       spi_cs;
  logic       spi_sck;
  logic       spi_mosi;
  logic       busy;

  modport slave (
    input  req, m0_cs, m0_sck, m0_mosi, m1_cs, m1_sck, m1_mosi,
    output gnt, spi_cs, spi_sck, spi_mosi, busy
  );

  modport master (
    output req, m0_cs, m0_sck, m0_mosi, m1_cs, m1_sck, m1_mosi,
    input  gnt, spi_cs, spi_sck, spi_mosi, busy
  );
endinterface

// File: rtl/spi_flash_arbiter.sv
// Purpose: shares the config SPI flash between USB bootloader (port 0) and user design (port 1).
// Latency: gnt rises/falls one clk after req; owner's SPI drive reaches the pins with zero register stages.
// Backpressure: a losing requester keeps req high and waits for release plus a GAP_CYCLES CS-high gap.
// Ports: clk_48mhz, rst_n (synchronous, active low), bus (slave modport: req/gnt, m0_*/m1_*, spi_*, busy).
module spi_flash_arbiter #(
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic               clk_48mhz,
  input  logic               rst_n,
  spi_flash_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_last;
  logic       w_last_nxt;
  logic [7:0] r_gap_cnt;
  logic [7:0] w_gap_cnt_nxt;
  logic [1:0] r_gnt;

  always_comb begin
    w_state_nxt   = r_state;
    w_last_nxt    = r_last;
    w_gap_cnt_nxt = r_gap_cnt;
    case (r_state)
      ST_IDLE: begin
        if (bus.req == 2'b01) begin
          w_state_nxt = ST_OWN0;
        end else if (bus.req == 2'b10) begin
          w_state_nxt = ST_OWN1;
        end else if (bus.req == 2'b11) begin
          // Contention: the port that did not own the flash last time wins.
          w_state_nxt = r_last ? ST_OWN0 : ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (!bus.req[0]) begin
          w_state_nxt   = ST_GAP;
          w_last_nxt    = 1'b0;
          w_gap_cnt_nxt = GAP_LOAD;
        end
      end
      ST_OWN1: begin
        if (!bus.req[1]) begin
          w_state_nxt   = ST_GAP;
          w_last_nxt    = 1'b1;
          w_gap_cnt_nxt = GAP_LOAD;
        end
      end
      ST_GAP: begin
        // Counter loaded with GAP_CYCLES-1 so the zero cycle is the last gap cycle.
        if (r_gap_cnt == 8'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_last    <= 1'b1;
      r_gap_cnt <= 8'd0;
      r_gnt     <= 2'b00;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      // Grant is its own flop (decode of next state) so it cannot glitch during state changes.
      r_gnt     <= {w_state_nxt == ST_OWN1, w_state_nxt == ST_OWN0};
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.busy = (r_state != ST_IDLE);

  // Pin mux keyed only on registered state: the non-owner never reaches the flash.
  always_comb begin
    bus.spi_cs   = 1'b1;
    bus.spi_sck  = 1'b0;
    bus.spi_mosi = 1'b0;
    case (r_state)
      ST_OWN0: begin
        bus.spi_cs   = bus.m0_cs;
        bus.spi_sck  = bus.m0_sck;
        bus.spi_mosi = bus.m0_mosi;
      end
      ST_OWN1: begin
        bus.spi_cs   = bus.m1_cs;
        bus.spi_sck  = bus.m1_sck;
        bus.spi_mosi = bus.m1_mosi;
      end
      default: begin
        bus.spi_cs   = 1'b1;
        bus.spi_sck  = 1'b0;
        bus.spi_mosi = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
module tb_spi_flash_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_flash_arbiter_if if0 ();
  spi_flash_arbiter_if if1 ();

  spi_flash_arbiter #(.GAP_CYCLES(4)) u_dut0 (
    .clk_48mhz (clk),
    .rst_n     (rst_n),
    .bus       (if0)
  );

  spi_flash_arbiter #(.GAP_CYCLES(1)) u_dut1 (
    .clk_48mhz (clk),
    .rst_n     (rst_n),
    .bus       (if1)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0] req;
    logic [2:0] m0;    // {cs, sck, mosi}
    logic [2:0] m1;
    logic [1:0] gnt;
    logic [2:0] pins;  // {spi_cs, spi_sck, spi_mosi}
    logic       busy;
  } vec_t;

  vec_t tbl[19];

  // Reference model: who owns the flash, how many cycles until arbitration may happen again, last owner.
  int own[2];
  int wt[2];
  int lst[2];
  int gapc[2];

  logic [1:0] cur_req;
  logic [2:0] cur_m0;
  logic [2:0] cur_m1;
  logic       cur_rst;
  int         low;
  int         seen;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic [2:0] a, input logic [2:0] b);
    cur_req = r;
    cur_m0  = a;
    cur_m1  = b;
    if0.req = r;
    {if0.m0_cs, if0.m0_sck, if0.m0_mosi} = a;
    {if0.m1_cs, if0.m1_sck, if0.m1_mosi} = b;
    if1.req = r;
    {if1.m0_cs, if1.m0_sck, if1.m0_mosi} = a;
    {if1.m1_cs, if1.m1_sck, if1.m1_mosi} = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input int d, input logic rn, input logic [1:0] r);
    if (!rn) begin
      own[d] = -1;
      wt[d]  = 0;
      lst[d] = 1;
    end else if (own[d] >= 0) begin
      if (!r[own[d]]) begin
        lst[d] = own[d];
        own[d] = -1;
        wt[d]  = gapc[d];
      end
    end else if (wt[d] > 0) begin
      wt[d] = wt[d] - 1;
    end else if (r != 2'b00) begin
      if (r == 2'b11) own[d] = 1 - lst[d];
      else            own[d] = r[1] ? 1 : 0;
    end
  endtask

  function automatic int exp_gnt(input int d);
    if (own[d] < 0) return 0;
    return 1 << own[d];
  endfunction

  function automatic int exp_pins(input int d, input logic [2:0] a, input logic [2:0] b);
    if (own[d] == 0) return int'(a);
    if (own[d] == 1) return int'(b);
    return 4;
  endfunction

  function automatic int exp_busy(input int d);
    return (own[d] >= 0 || wt[d] > 0) ? 1 : 0;
  endfunction

  initial begin
    gapc[0] = 4;
    gapc[1] = 1;
    // Simultaneous request after reset goes to port 0; port 1 drive never leaks.
    tbl[0]  = '{2'b11, 3'b011, 3'b111, 2'b01, 3'b011, 1'b1};
    tbl[1]  = '{2'b11, 3'b001, 3'b010, 2'b01, 3'b001, 1'b1};
    tbl[2]  = '{2'b11, 3'b011, 3'b000, 2'b01, 3'b011, 1'b1};
    // Port 0 drops while its cs is low: pins idle at once, gap of 4, then idle cycle.
    tbl[3]  = '{2'b10, 3'b011, 3'b010, 2'b00, 3'b100, 1'b1};
    tbl[4]  = '{2'b10, 3'b001, 3'b000, 2'b00, 3'b100, 1'b1};
    tbl[5]  = '{2'b10, 3'b010, 3'b011, 2'b00, 3'b100, 1'b1};
    tbl[6]  = '{2'b10, 3'b011, 3'b001, 2'b00, 3'b100, 1'b1};
    tbl[7]  = '{2'b10, 3'b000, 3'b011, 2'b00, 3'b100, 1'b0};
    // Port 1 owns; port 0 pulses are ignored.
    tbl[8]  = '{2'b10, 3'b111, 3'b010, 2'b10, 3'b010, 1'b1};
    tbl[9]  = '{2'b11, 3'b011, 3'b001, 2'b10, 3'b001, 1'b1};
    tbl[10] = '{2'b10, 3'b000, 3'b100, 2'b10, 3'b100, 1'b1};
    tbl[11] = '{2'b11, 3'b001, 3'b011, 2'b10, 3'b011, 1'b1};
    // Port 1 releases, port 0 pending: 4 gap cycles, idle cycle, grant 0.
    tbl[12] = '{2'b01, 3'b011, 3'b001, 2'b00, 3'b100, 1'b1};
    tbl[13] = '{2'b01, 3'b010, 3'b001, 2'b00, 3'b100, 1'b1};
    tbl[14] = '{2'b01, 3'b001, 3'b000, 2'b00, 3'b100, 1'b1};
    tbl[15] = '{2'b01, 3'b011, 3'b011, 2'b00, 3'b100, 1'b1};
    tbl[16] = '{2'b01, 3'b010, 3'b011, 2'b00, 3'b100, 1'b0};
    tbl[17] = '{2'b01, 3'b110, 3'b000, 2'b01, 3'b110, 1'b1};
    tbl[18] = '{2'b00, 3'b000, 3'b011, 2'b00, 3'b100, 1'b1};

    // Reset state
    rst_n = 1'b0;
    drive(2'b00, 3'b000, 3'b000);
    step();
    step();
    chk("rst_gnt", int'(if0.gnt), 0);
    chk("rst_pins", int'({if0.spi_cs, if0.spi_sck, if0.spi_mosi}), 4);
    chk("rst_busy", int'(if0.busy), 0);
    rst_n = 1'b1;

    // Table-driven vectors on the GAP_CYCLES=4 instance
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].req, tbl[i].m0, tbl[i].m1);
      step();
      chk($sformatf("tbl%0d_gnt", i), int'(if0.gnt), int'(tbl[i].gnt));
      chk($sformatf("tbl%0d_pins", i), int'({if0.spi_cs, if0.spi_sck, if0.spi_mosi}), int'(tbl[i].pins));
      chk($sformatf("tbl%0d_busy", i), int'(if0.busy), int'(tbl[i].busy));
    end

    // Reset while port 1 owns with cs low
    drive(2'b10, 3'b000, 3'b011);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (if0.gnt == 2'b10) begin
        seen = 1;
        break;
      end
    end
    chk("own1_reached", seen, 1);
    chk("own1_pins", int'({if0.spi_cs, if0.spi_sck, if0.spi_mosi}), 3);
    rst_n = 1'b0;
    step();
    chk("midrst_gnt", int'(if0.gnt), 0);
    chk("midrst_pins", int'({if0.spi_cs, if0.spi_sck, if0.spi_mosi}), 4);
    chk("midrst_busy", int'(if0.busy), 0);
    rst_n = 1'b1;
    drive(2'b11, 3'b011, 3'b011);
    step();
    chk("postrst_gnt", int'(if0.gnt), 1);

    // GAP_CYCLES=1 instance: port 0 toggles, gnt[0] low for exactly 2 cycles per drop
    rst_n = 1'b0;
    drive(2'b01, 3'b100, 3'b000);
    step();
    rst_n = 1'b1;
    step();
    chk("g1_first_gnt", int'(if1.gnt), 1);
    for (int t = 0; t < 3; t++) begin
      drive(2'b00, 3'b100, 3'b000);
      step();
      chk($sformatf("g1_drop%0d_gnt", t), int'(if1.gnt), 0);
      drive(2'b01, 3'b100, 3'b000);
      low = 1;
      for (int k = 0; k < 10; k++) begin
        step();
        if (if1.gnt == 2'b01) break;
        low++;
      end
      chk($sformatf("g1_low%0d", t), low, 2);
    end

    // Randomized run on both instances against the reference model
    rst_n   = 1'b0;
    cur_rst = 1'b0;
    drive(2'b00, 3'b000, 3'b000);
    step();
    for (int d = 0; d < 2; d++) model_step(d, 1'b0, 2'b00);
    rst_n   = 1'b1;
    cur_rst = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      logic [1:0] r;
      r = cur_req;
      if ($urandom_range(3) == 0) r[0] = ~r[0];
      if ($urandom_range(3) == 0) r[1] = ~r[1];
      cur_rst = ($urandom_range(99) != 0);
      rst_n   = cur_rst;
      drive(r, 3'($urandom_range(7)), 3'($urandom_range(7)));
      step();
      for (int d = 0; d < 2; d++) model_step(d, cur_rst, cur_req);
      chk("rnd0_gnt", int'(if0.gnt), exp_gnt(0));
      chk("rnd0_busy", int'(if0.busy), exp_busy(0));
      chk("rnd0_pins", int'({if0.spi_cs, if0.spi_sck, if0.spi_mosi}), exp_pins(0, cur_m0, cur_m1));
      chk("rnd1_gnt", int'(if1.gnt), exp_gnt(1));
      chk("rnd1_busy", int'(if1.busy), exp_busy(1));
      chk("rnd1_pins", int'({if1.spi_cs, if1.spi_sck, if1.spi_mosi}), exp_pins(1, cur_m0, cur_m1));
      // Pins must follow the owner's drive combinationally, mid-cycle.
      drive(cur_req, 3'($urandom_range(7)), 3'($urandom_range(7)));
      #1;
      chk("rnd0_pass", int'({if0.spi_cs, if0.spi_sck, if0.spi_mosi}), exp_pins(0, cur_m0, cur_m1));
      chk("rnd1_pass", int'({if1.spi_cs, if1.spi_sck, if1.spi_mosi}), exp_pins(1, cur_m0, cur_m1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
